// File: rtl/alu_multibyte_seq.sv
// alu_multibyte_seq: multi-cycle sequencer that drives an 8-bit cpu_alu to perform
// NBYTES-wide ADD / SUB / AND / MOVE. Bytes are processed LSB first. The carry or
// borrow is chained between bytes by choosing the matching ALU SEL encoding.
// Optional feature: define ALU_SEQ_OVF_EN to add the signed-overflow output 'ovf'.
module alu_multibyte_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic                  cin,
    input  logic [8*NBYTES-1:0]   opa,
    input  logic [8*NBYTES-1:0]   opb,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  cout,
    output logic                  zero,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic [4:0]            alu_sel,
    input  logic [7:0]            alu_z,
    input  logic                  alu_cout
`ifdef ALU_SEQ_OVF_EN
    ,
    output logic                  ovf
`endif
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MOVE = 2'b11;

    // ALU SEL encodings; PARK keeps the ALU in a harmless state while idle
    localparam logic [4:0] SEL_ADD   = 5'b00000;
    localparam logic [4:0] SEL_ADDC  = 5'b00100;
    localparam logic [4:0] SEL_SUB   = 5'b01100;
    localparam logic [4:0] SEL_SUBB  = 5'b01000;
    localparam logic [4:0] SEL_AND   = 5'b00001;
    localparam logic [4:0] SEL_MOVE  = 5'b00011;
    localparam logic [4:0] SEL_PARK  = 5'b11111;

    localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic [1:0]      op_q;
    logic            c_q;
    logic            busy_q;
    logic            done_q;
    logic [W-1:0]    result_q;
    logic            cout_q;
    logic            zero_q;
    logic [7:0]      alu_a_q;
    logic [7:0]      alu_b_q;
    logic [4:0]      alu_sel_q;
    logic [W-1:0]    opa_q;
    logic [W-1:0]    opb_q;
`ifdef ALU_SEQ_OVF_EN
    logic            ovf_q;
`endif

    // combinational helpers for the RUN step
    logic            accept;
    logic            arith;
    logic            c_d;
    logic [IW-1:0]   idx_d;
    logic [W-1:0]    result_d;

    // SEL for a byte given the operation and the incoming carry/borrow
    function automatic logic [4:0] sel_for(input logic [1:0] o, input logic c);
        logic [4:0] s;
        case (o)
            OP_ADD:  s = c ? SEL_ADDC : SEL_ADD;
            OP_SUB:  s = c ? SEL_SUBB : SEL_SUB;
            OP_AND:  s = SEL_AND;
            default: s = SEL_MOVE;
        endcase
        return s;
    endfunction

    assign accept = (state_q == S_IDLE) && start && !busy_q;
    assign arith  = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign c_d    = arith ? alu_cout : c_q;
    assign idx_d  = idx_q + IW'(1);

    // Result with the current ALU byte merged in at position idx
    always_comb begin
        result_d = result_q;
        result_d[8*int'(idx_q) +: 8] = alu_z;
    end

    // Operand latches: plain data, captured only when a request is accepted
    always_ff @(posedge clk) begin
        if (accept) begin
            opa_q <= opa;
            opb_q <= opb;
        end
    end

    // Sequencer FSM with registered status, result and ALU drive outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            op_q      <= OP_ADD;
            c_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            cout_q    <= 1'b0;
            zero_q    <= 1'b0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= SEL_PARK;
`ifdef ALU_SEQ_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        state_q   <= S_RUN;
                        busy_q    <= 1'b1;
                        op_q      <= op;
                        c_q       <= cin;
                        idx_q     <= '0;
                        alu_a_q   <= opa[7:0];
                        alu_b_q   <= opb[7:0];
                        alu_sel_q <= sel_for(op, cin);
                    end
                end

                S_RUN: begin
                    result_q <= result_d;
                    c_q      <= c_d;
                    if (idx_q == IDX_LAST) begin
                        // final byte captured: publish flags and park the ALU
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        idx_q     <= '0;
                        cout_q    <= arith ? alu_cout : 1'b0;
                        zero_q    <= (result_d == '0);
                        alu_a_q   <= '0;
                        alu_b_q   <= '0;
                        alu_sel_q <= SEL_PARK;
`ifdef ALU_SEQ_OVF_EN
                        case (op_q)
                            OP_ADD:  ovf_q <= (opa_q[W-1] == opb_q[W-1]) &&
                                              (result_d[W-1] != opa_q[W-1]);
                            OP_SUB:  ovf_q <= (opa_q[W-1] != opb_q[W-1]) &&
                                              (result_d[W-1] != opa_q[W-1]);
                            default: ovf_q <= 1'b0;
                        endcase
`endif
                    end else begin
                        // advance to the next byte using the carry just produced
                        idx_q     <= idx_d;
                        alu_a_q   <= opa_q[8*int'(idx_d) +: 8];
                        alu_b_q   <= opb_q[8*int'(idx_d) +: 8];
                        alu_sel_q <= sel_for(op_q, c_d);
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q   <= S_IDLE;
                    done_q    <= 1'b0;
                    busy_q    <= 1'b0;
                    alu_a_q   <= '0;
                    alu_b_q   <= '0;
                    alu_sel_q <= SEL_PARK;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign cout    = cout_q;
    assign zero    = zero_q;
    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_sel = alu_sel_q;
`ifdef ALU_SEQ_OVF_EN
    assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_alu_multibyte_seq.sv
// Testbench for alu_multibyte_seq (NBYTES=4) with a behavioural 8-bit ALU model.
// Expected results are queued at issue time; a monitor pops them on each done pulse.
module tb_alu_multibyte_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic        cin;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        cout;
    logic        zero;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [4:0]  alu_sel;
    logic [7:0]  alu_z;
    logic        alu_cout;
`ifdef ALU_SEQ_OVF_EN
    logic        ovf;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cnt  = 0;
    int acc_last = 0;
    int acc_prev = 0;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        z;
        logic        o;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];

    always #5 clk = ~clk;

    alu_multibyte_seq #(.NBYTES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .cin      (cin),
        .opa      (opa),
        .opb      (opb),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .zero     (zero),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_sel  (alu_sel),
        .alu_z    (alu_z),
        .alu_cout (alu_cout)
`ifdef ALU_SEQ_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    // Behavioural model of the 8-bit cpu_alu for the SEL codes the sequencer uses
    always_comb begin
        logic [8:0] t;
        t = 9'd0;
        case (alu_sel)
            5'b00000: t = {1'b0, alu_a} + {1'b0, alu_b};
            5'b00100: t = {1'b0, alu_a} + {1'b0, alu_b} + 9'd1;
            5'b01100: t = {1'b0, alu_a} - {1'b0, alu_b};
            5'b01000: t = {1'b0, alu_a} - {1'b0, alu_b} - 9'd1;
            5'b00001: t = {1'b0, alu_a & alu_b};
            5'b00011: t = {1'b0, alu_b};
            default:  t = 9'd0;
        endcase
        alu_z    = t[7:0];
        alu_cout = t[8];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Cycle counter and accept log (what the DUT should have accepted this edge)
    always @(posedge clk) begin
        if (rst) begin
            acc_q.delete();
        end else if (start && !busy) begin
            acc_q.push_back(cyc);
            acc_prev = acc_last;
            acc_last = cyc;
            acc_cnt++;
        end
        cyc <= cyc + 1;
    end

    // Monitor: compare each done pulse against the oldest queued expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            int   a;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                e = exp_q.pop_front();
                chk("result", result, e.r);
                chk("cout", {31'd0, cout}, {31'd0, e.c});
                chk("zero", {31'd0, zero}, {31'd0, e.z});
                chk("busy_at_done", {31'd0, busy}, 32'd1);
`ifdef ALU_SEQ_OVF_EN
                chk("ovf", {31'd0, ovf}, {31'd0, e.o});
`endif
                if (acc_q.size() != 0) begin
                    a = acc_q.pop_front();
                    chk("latency", 32'(cyc - a), 32'd5);
                end else begin
                    total++;
                    bad++;
                    $display("FAIL latency: got no accept record expected one");
                end
            end
        end
    end

    // Issue one request when idle; operands are scrambled while busy to show they are ignored
    task automatic issue(input logic [1:0] o, input logic ci, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic ec,
                         input logic ez, input logic eo);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL issue_wait: got busy=%0b expected 0", busy);
        end
        op    = o;
        cin   = ci;
        opa   = a;
        opb   = b;
        start = 1'b1;
        exp_q.push_back('{r: er, c: ec, z: ez, o: eo});
        @(negedge clk);
        start = 1'b0;
        opa   = 32'hDEADBEEF;
        opb   = 32'h5A5A5A5A;
        op    = ~o;
        cin   = ~ci;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL wait_idle: got busy=%0b pending=%0d expected idle", busy, exp_q.size());
        end
    endtask

    initial begin
        int c0;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        cin   = 1'b0;
        opa   = '0;
        opb   = '0;
        repeat (3) @(negedge clk);

        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_cout_zero", {30'd0, cout, zero}, 32'd0);
        chk("rst_sel", {27'd0, alu_sel}, 32'h1F);
        chk("rst_ab", {16'd0, alu_a, alu_b}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(2'b00, 1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 1'b0);
        wait_idle();

        issue(2'b00, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0);
        chk("sel_b0", {27'd0, alu_sel}, 32'h00);
        chk("a_b0", {24'd0, alu_a}, 32'hFF);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("sel_carry", {27'd0, alu_sel}, 32'h04);
        end
        @(negedge clk);
        chk("sel_park_done", {27'd0, alu_sel}, 32'h1F);
        chk("done_pulse", {31'd0, done}, 32'd1);
        wait_idle();

        issue(2'b01, 1'b0, 32'h00000100, 32'h00000001, 32'h000000FF, 1'b0, 1'b0, 1'b0);
        issue(2'b01, 1'b0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        issue(2'b10, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0);
        issue(2'b11, 1'b1, 32'hAAAAAAAA, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b0);
        issue(2'b00, 1'b1, 32'h00000000, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 1'b0);
        issue(2'b01, 1'b1, 32'h00000005, 32'h00000002, 32'h00000002, 1'b0, 1'b0, 1'b0);
        issue(2'b00, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1);
        issue(2'b01, 1'b0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1);
        issue(2'b00, 1'b0, 32'h00000001, 32'h00000001, 32'h00000002, 1'b0, 1'b0, 1'b0);
        wait_idle();

        // start held high for 10 cycles: exactly two accepts, 6 cycles apart
        c0    = acc_cnt;
        op    = 2'b00;
        cin   = 1'b0;
        opa   = 32'h00000001;
        opb   = 32'h00000002;
        start = 1'b1;
        exp_q.push_back('{r: 32'h3, c: 1'b0, z: 1'b0, o: 1'b0});
        exp_q.push_back('{r: 32'h3, c: 1'b0, z: 1'b0, o: 1'b0});
        repeat (10) @(negedge clk);
        start = 1'b0;
        chk("held_accepts", 32'(acc_cnt - c0), 32'd2);
        chk("held_spacing", 32'(acc_last - acc_prev), 32'd6);
        wait_idle();

        // reset during the second RUN cycle discards the operation
        opa   = 32'h11111111;
        opb   = 32'h22222222;
        op    = 2'b00;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_sel", {27'd0, alu_sel}, 32'h1F);
        chk("mid_rst_flags", {29'd0, done, cout, zero}, 32'd0);
        chk("mid_rst_a", {24'd0, alu_a}, 32'd0);

        // reset and start together: reset wins, nothing accepted
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("rst_start_busy2", {31'd0, busy}, 32'd0);
        repeat (8) @(negedge clk);
        chk("no_stray_pending", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
